mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipeline's instruction-fetch port (Iaddr/Inst) and data port (Daddr/Dwrite/Dread/Wmem).
- Grants one transaction at a time, with data priority by default, and drives a multi-cycle memory handshake.
- Generates a Stall signal that freezes PC and the IF_ID/ID_EX/EX_MEM/MEM_WB write enables while any request is outstanding.
- Bus watchdog terminates hung transactions and raises a sticky error flag.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_timeout_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int TIMEOUT_CYC_DEF  = 16;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IBUSY = 2'd1,
    ARB_DBUSY = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_src_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// Bus watchdog: counts cycles of an outstanding memory request, loaded to 1 at grant.
// expire flags the TIMEOUT_CYC-th request cycle; TIMEOUT_CYC = 0 disables it.
module arb_timeout_counter #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic Clk,
  input  logic Clrn,
  input  logic load,
  input  logic active,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 2);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Clrn) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (active && !expire) begin
      count <= count + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_wdog
      assign expire = 1'b0;
    end else begin : g_wdog
      assign expire = (count == CW'(TIMEOUT_CYC));
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-ported memory, data first by default.
// Optional MEM_ARB_STARVE_GUARD_EN forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              I_req,
  input  logic [ADDR_W-1:0] I_addr,
  output logic [DATA_W-1:0] I_rdata,
  output logic              I_ready,
  input  logic              D_req,
  input  logic              D_we,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic [DATA_W-1:0] D_rdata,
  output logic              D_ready,
  output logic              M_req,
  output logic              M_we,
  output logic [ADDR_W-1:0] M_addr,
  output logic [DATA_W-1:0] M_wdata,
  input  logic [DATA_W-1:0] M_rdata,
  input  logic              M_ack,
  output logic              Stall,
  output logic              Err
);

  arb_state_e        state;
  gnt_src_e          gnt;
  logic              i_elig;
  logic              d_elig;
  logic              starve_hit;
  logic              expire;
  logic              done;
  logic [DATA_W-1:0] cap_data;

  // A port is not re-arbitrated in the cycle its ready pulse is out.
  assign i_elig   = I_req & ~I_ready;
  assign d_elig   = D_req & ~D_ready;
  assign Stall    = i_elig | d_elig;
  assign done     = M_ack | expire;
  assign cap_data = M_ack ? M_rdata : '0;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge Clk) begin
    if (Clrn) begin
      starve_cnt <= '0;
    end else if (gnt == GNT_I) begin
      starve_cnt <= '0;
    end else if (gnt == GNT_D && i_elig) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // NOTE: gnt is assigned a default before any branch so this block cannot infer a latch.
  always_comb begin
    gnt = GNT_NONE;
    if (state == ARB_IDLE) begin
      if (d_elig && !(starve_hit && i_elig)) begin
        gnt = GNT_D;
      end else if (i_elig) begin
        gnt = GNT_I;
      end
    end
  end

  arb_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .Clk    (Clk),
    .Clrn   (Clrn),
    .load   (gnt != GNT_NONE),
    .active (M_req),
    .expire (expire)
  );

  always_ff @(posedge Clk) begin
    if (Clrn) begin
      state   <= ARB_IDLE;
      M_req   <= 1'b0;
      M_we    <= 1'b0;
      M_addr  <= '0;
      M_wdata <= '0;
      I_rdata <= '0;
      D_rdata <= '0;
      I_ready <= 1'b0;
      D_ready <= 1'b0;
      Err     <= 1'b0;
    end else begin
      I_ready <= 1'b0;
      D_ready <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (gnt == GNT_D) begin
            M_req   <= 1'b1;
            M_we    <= D_we;
            M_addr  <= D_addr;
            M_wdata <= D_wdata;
            state   <= ARB_DBUSY;
          end else if (gnt == GNT_I) begin
            M_req  <= 1'b1;
            M_we   <= 1'b0;
            M_addr <= I_addr;
            state  <= ARB_IBUSY;
          end
        end
        ARB_IBUSY, ARB_DBUSY: begin
          if (done) begin
            M_req <= 1'b0;
            M_we  <= 1'b0;
            state <= ARB_IDLE;
            if (state == ARB_IBUSY) begin
              I_rdata <= cap_data;
              I_ready <= 1'b1;
            end else begin
              D_rdata <= cap_data;
              D_ready <= 1'b1;
            end
            // A late ack in the timeout cycle still counts as a clean completion.
            if (!M_ack) begin
              Err <= 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
// Honours MEM_ARB_STARVE_GUARD_EN in the model when the build defines it.
module tb_mem_port_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;
  localparam int STARVE  = 2;
  localparam int NCYC    = 4000;
  localparam int HANG    = 1000;

  logic          Clk = 1'b0;
  logic          Clrn;
  logic          I_req, I_ready, D_req, D_we, D_ready;
  logic [AW-1:0] I_addr, D_addr, M_addr;
  logic [DW-1:0] I_rdata, D_rdata, D_wdata, M_wdata, M_rdata;
  logic          M_req, M_we, M_ack, Stall, Err;

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .TIMEOUT_CYC  (TIMEOUT),
    .STARVE_LIMIT (STARVE)
  ) dut (
    .Clk     (Clk),
    .Clrn    (Clrn),
    .I_req   (I_req),
    .I_addr  (I_addr),
    .I_rdata (I_rdata),
    .I_ready (I_ready),
    .D_req   (D_req),
    .D_we    (D_we),
    .D_addr  (D_addr),
    .D_wdata (D_wdata),
    .D_rdata (D_rdata),
    .D_ready (D_ready),
    .M_req   (M_req),
    .M_we    (M_we),
    .M_addr  (M_addr),
    .M_wdata (M_wdata),
    .M_rdata (M_rdata),
    .M_ack   (M_ack),
    .Stall   (Stall),
    .Err     (Err)
  );

  always #5 Clk = ~Clk;

  // One outstanding memory transaction as the specification describes it.
  typedef struct {
    bit            busy;
    bit            is_d;
    int            age;
    int            ack_at;
    bit            we;
    logic [AW-1:0] addr;
  } txn_t;

  txn_t          cur;
  bit            e_iready, e_dready, e_err;
  logic [DW-1:0] e_irdata, e_drdata, e_mwdata;
  logic [AW-1:0] e_maddr;
  int            starve_cnt;
  int            n_vec  = 0;
  int            n_miss = 0;
  int            n_to   = 0;
  int            n_rst  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur        = '{busy: 1'b0, is_d: 1'b0, age: 0, ack_at: 0, we: 1'b0, addr: '0};
    e_iready   = 1'b0;
    e_dready   = 1'b0;
    e_err      = 1'b0;
    e_irdata   = '0;
    e_drdata   = '0;
    e_mwdata   = '0;
    e_maddr    = '0;
    starve_cnt = 0;
  endtask

  function automatic int pick_ack_delay();
    int r;
    r = $urandom_range(0, 15);
    if (r < 5)  return 0;
    if (r < 9)  return 1;
    if (r < 12) return 2;
    if (r < 14) return 3;
    return HANG;
  endfunction

  task automatic start_txn(input bit is_d);
    cur.busy   = 1'b1;
    cur.is_d   = is_d;
    cur.age    = 0;
    cur.ack_at = pick_ack_delay();
    cur.we     = is_d ? D_we : 1'b0;
    cur.addr   = is_d ? D_addr : I_addr;
    e_maddr    = cur.addr;
    if (is_d) e_mwdata = D_wdata;
  endtask

  // Advances the model across one rising edge, using the inputs currently driven.
  task automatic model_step();
    bit ni, nd, ie, de, fin;
    logic [DW-1:0] val;
    if (Clrn) begin
      model_reset();
      return;
    end
    ni  = 1'b0;
    nd  = 1'b0;
    fin = 1'b0;
    val = '0;
    if (cur.busy) begin
      if (M_ack) begin
        fin = 1'b1;
        val = M_rdata;
      end else if (cur.age + 1 == TIMEOUT) begin
        fin   = 1'b1;
        e_err = 1'b1;
        n_to++;
      end else begin
        cur.age++;
      end
      if (fin) begin
        cur.busy = 1'b0;
        if (cur.is_d) begin
          e_drdata = val;
          nd = 1'b1;
        end else begin
          e_irdata = val;
          ni = 1'b1;
        end
      end
    end else begin
      ie = I_req && !e_iready;
      de = D_req && !e_dready;
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (ie && (!de || starve_cnt == STARVE)) begin
        start_txn(1'b0);
        starve_cnt = 0;
      end else if (de) begin
        start_txn(1'b1);
        if (ie) starve_cnt++;
      end
`else
      if (de) start_txn(1'b1);
      else if (ie) start_txn(1'b0);
`endif
    end
    e_iready = ni;
    e_dready = nd;
  endtask

  task automatic check_outputs();
    check("m_req",   M_req,   cur.busy);
    check("m_we",    M_we,    cur.busy && cur.we);
    check("m_addr",  M_addr,  e_maddr);
    check("m_wdata", M_wdata, e_mwdata);
    check("i_ready", I_ready, e_iready);
    check("d_ready", D_ready, e_dready);
    check("i_rdata", I_rdata, e_irdata);
    check("d_rdata", D_rdata, e_drdata);
    check("err",     Err,     e_err);
  endtask

  initial begin
    bit i_hold, d_hold;
    Clrn    = 1'b1;
    I_req   = 1'b0;
    I_addr  = '0;
    D_req   = 1'b0;
    D_we    = 1'b0;
    D_addr  = '0;
    D_wdata = '0;
    M_rdata = '0;
    M_ack   = 1'b0;
    i_hold  = 1'b0;
    d_hold  = 1'b0;
    model_reset();
    @(negedge Clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      check_outputs();

      Clrn = (cyc > 0) && ($urandom_range(0, 149) == 0);
      if (Clrn) n_rst++;

      // Requesters hold through their ready cycle, then drop or issue a fresh request.
      if (e_iready) begin
        i_hold = 1'b1;
      end else if (i_hold || !I_req) begin
        i_hold = 1'b0;
        I_req  = ($urandom_range(0, 2) != 0);
        I_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (e_dready) begin
        d_hold = 1'b1;
      end else if (d_hold || !D_req) begin
        d_hold  = 1'b0;
        D_req   = ($urandom_range(0, 2) != 0);
        D_we    = $urandom_range(0, 1);
        D_addr  = $urandom() & 32'hFFFF_FFFC;
        D_wdata = $urandom();
      end

      // Memory acks after the delay chosen at grant; idle-time acks are noise.
      M_ack   = cur.busy ? (cur.age >= cur.ack_at) : ($urandom_range(0, 3) == 0);
      M_rdata = $urandom();

      #1;
      check("stall", Stall, (I_req && !e_iready) || (D_req && !e_dready));
      model_step();
      @(negedge Clk);
    end

    check_outputs();
    $display("timeouts modelled: %0d, resets applied: %0d", n_to, n_rst);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
